// File: rtl/qdec_pkg.sv
// Shared definitions for the quadrature decoder.
//   - {a,b} state encodings S00/S10/S11/S01 (A leads B when counting up)
//   - direction constants DIR_UP / DIR_DN
//   - qdec_decode(): classifies a prev->curr state pair as {valid, up, illegal}
package qdec_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S01 = 2'b01;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef struct packed {
    logic valid;    // single-bit change: one step
    logic up;       // step direction, meaningful only when valid
    logic illegal;  // both bits changed
  } dec_t;

  function automatic dec_t qdec_decode(input logic [1:0] prev, input logic [1:0] curr);
    dec_t       d;
    logic [1:0] nxt_up;
    d = '0;
    case (prev)
      S00:     nxt_up = S10;
      S10:     nxt_up = S11;
      S11:     nxt_up = S01;
      default: nxt_up = S00;
    endcase
    if (prev != curr) begin
      if ((prev ^ curr) == 2'b11) begin
        d.illegal = 1'b1;
      end else begin
        d.valid = 1'b1;
        d.up    = (curr == nxt_up);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// One-bit 2-flop synchroniser followed by a stability filter.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   i_d  - asynchronous input
//   o_q  - filtered output; follows the synchronised value once it has
//          differed from o_q for FILT_LEN consecutive cycles
module qdec_sync_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  localparam int CW = $clog2(FILT_LEN + 1);

  logic          r_s1, r_s2, r_q;
  logic [CW-1:0] r_cnt;

  // Input is a single bit, so "differs from r_q" means "holds the one other
  // value"; any return to r_q restarts the count, dropping short pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_q   <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      if (r_s2 == r_q) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT_LEN - 1)) begin
        r_q   <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises and filters A/B/Z, decodes the filtered
// A/B state against the previous state and keeps a modulo-2^N position.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   qa, qb, qz      - encoder phases and index (asynchronous)
//   en              - count enable
//   clr             - synchronous clear of pos
//   err_clr         - synchronous clear of err
//   pos             - position count
//   dir             - direction of last counted step (1 = up)
//   step            - one-cycle pulse per counted step
//   err             - sticky illegal-transition flag
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int N        = 16,
  parameter int FILT_LEN = 3,
  parameter bit IDX_CLR  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         qa,
  input  logic         qb,
  input  logic         qz,
  input  logic         en,
  input  logic         clr,
  input  logic         err_clr,
  output logic [N-1:0] pos,
  output logic         dir,
  output logic         step,
  output logic         err
);
  // Cycles from reset release until a level present at release has made it
  // through the synchroniser and the filter.
  localparam int SETTLE = 2 + FILT_LEN;
  localparam int SW     = $clog2(SETTLE + 1);

  logic          w_a, w_b, w_z, w_zrise;
  logic [1:0]    w_ab;
  dec_t          w_dec;

  logic [1:0]    r_prev;
  logic          r_zprev;
  logic          r_primed;
  logic [SW-1:0] r_settle;
  logic [N-1:0]  r_pos;
  logic          r_dir, r_step, r_err;

  qdec_sync_filter #(.FILT_LEN(FILT_LEN)) u_fa (.clk(clk), .rst(rst), .i_d(qa), .o_q(w_a));
  qdec_sync_filter #(.FILT_LEN(FILT_LEN)) u_fb (.clk(clk), .rst(rst), .i_d(qb), .o_q(w_b));
  qdec_sync_filter #(.FILT_LEN(FILT_LEN)) u_fz (.clk(clk), .rst(rst), .i_d(qz), .o_q(w_z));

  assign w_ab    = {w_a, w_b};
  assign w_dec   = qdec_decode(r_prev, w_ab);
  assign w_zrise = IDX_CLR && r_primed && w_z && !r_zprev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev   <= S00;
      r_zprev  <= 1'b0;
      r_primed <= 1'b0;
      r_settle <= '0;
      r_pos    <= '0;
      r_dir    <= DIR_DN;
      r_step   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (!r_primed) begin
        // Wait for the filters to settle, then adopt their state as the
        // reference without decoding, so a resting 11 is not an error.
        if (r_settle == SW'(SETTLE)) begin
          r_prev   <= w_ab;
          r_zprev  <= w_z;
          r_primed <= 1'b1;
        end else begin
          r_settle <= r_settle + 1'b1;
        end
        if (clr)     r_pos <= '0;
        if (err_clr) r_err <= 1'b0;
      end else begin
        r_prev  <= w_ab;
        r_zprev <= w_z;
        // A new illegal transition beats a same-cycle clear.
        if (w_dec.illegal)  r_err <= 1'b1;
        else if (err_clr)   r_err <= 1'b0;
        if (en && w_dec.valid) begin
          r_step <= 1'b1;
          r_dir  <= w_dec.up ? DIR_UP : DIR_DN;
        end
        if (clr || w_zrise)         r_pos <= '0;
        else if (en && w_dec.valid) r_pos <= w_dec.up ? r_pos + 1'b1 : r_pos - 1'b1;
      end
    end
  end

  assign pos  = r_pos;
  assign dir  = r_dir;
  assign step = r_step;
  assign err  = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;
  logic        clk = 1'b0;
  logic        rst, qa, qb, qz, en, clr, err_clr;
  logic [15:0] pos;
  logic        dir, step, err;

  int          n_cmp = 0;
  int          n_err = 0;
  int          step_cnt = 0;
  logic [1:0]  ab;

  quad_decoder #(.N(16), .FILT_LEN(3), .IDX_CLR(1'b1)) dut (
    .clk(clk), .rst(rst), .qa(qa), .qb(qb), .qz(qz), .en(en), .clr(clr),
    .err_clr(err_clr), .pos(pos), .dir(dir), .step(step), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (step === 1'b1) step_cnt++;

  // Up order 00->10->11->01->00 as a lookup table.
  function automatic logic [1:0] nxt(input logic [1:0] s, input bit up);
    logic [1:0] r;
    if (up) case (s) 2'b00: r = 2'b10; 2'b10: r = 2'b11; 2'b11: r = 2'b01; default: r = 2'b00; endcase
    else    case (s) 2'b00: r = 2'b01; 2'b01: r = 2'b11; 2'b11: r = 2'b10; default: r = 2'b00; endcase
    return r;
  endfunction

  // Drive one quadrature edge at a falling clock edge and hold it.
  task automatic mv(input bit up, input int hold);
    @(negedge clk);
    ab = nxt(ab, up);
    {qa, qb} = ab;
    repeat (hold) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; qa = 0; qb = 0; qz = 0; en = 1; clr = 0; err_clr = 0; ab = 2'b00;
    repeat (3) @(negedge clk);
    n_cmp++; if (pos !== 16'd0) begin n_err++; $display("FAIL reset_pos got %0d want 0", pos); end
    n_cmp++; if ({dir, step, err} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {dir, step, err}); end
    rst = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++; if ({pos, err} !== 17'd0) begin n_err++; $display("FAIL post_reset got pos=%0d err=%b want 0/0", pos, err); end
  endtask

  task automatic test_up_count;
    int c0;
    c0 = step_cnt;
    @(negedge clk);
    ab = nxt(ab, 1'b1); {qa, qb} = ab;
    repeat (5) @(negedge clk);
    n_cmp++; if (pos !== 16'd0) begin n_err++; $display("FAIL latency_early got %0d want 0", pos); end
    @(negedge clk);
    n_cmp++; if (pos !== 16'd1 || step !== 1'b1) begin n_err++; $display("FAIL latency_6 got pos=%0d step=%b want 1/1", pos, step); end
    @(negedge clk);
    n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL step_pulse got %b want 0", step); end
    repeat (7) @(negedge clk);
    for (int i = 0; i < 31; i++) mv(1'b1, 10);
    n_cmp++; if (pos !== 16'd32 || dir !== 1'b1 || err !== 1'b0) begin n_err++; $display("FAIL up32 got pos=%0d dir=%b err=%b want 32/1/0", pos, dir, err); end
    n_cmp++; if (step_cnt - c0 !== 32) begin n_err++; $display("FAIL up32_steps got %0d want 32", step_cnt - c0); end
  endtask

  task automatic test_wrap;
    @(negedge clk); clr = 1'b1; @(negedge clk); clr = 1'b0;
    n_cmp++; if (pos !== 16'd0) begin n_err++; $display("FAIL clr got %0d want 0", pos); end
    mv(1'b0, 10);
    n_cmp++; if (pos !== 16'hFFFF || dir !== 1'b0) begin n_err++; $display("FAIL wrap_dn got pos=%0d dir=%b want 65535/0", pos, dir); end
    mv(1'b1, 10);
    n_cmp++; if (pos !== 16'd0 || dir !== 1'b1) begin n_err++; $display("FAIL wrap_up got pos=%0d dir=%b want 0/1", pos, dir); end
    mv(1'b0, 10);
    n_cmp++; if (pos !== 16'hFFFF || dir !== 1'b0) begin n_err++; $display("FAIL wrap_dn2 got pos=%0d dir=%b want 65535/0", pos, dir); end
  endtask

  task automatic test_glitch;
    int c0;
    c0 = step_cnt;
    @(negedge clk); qa = ~ab[1];
    repeat (2) @(negedge clk); qa = ab[1];
    repeat (12) @(negedge clk);
    n_cmp++; if (pos !== 16'hFFFF || err !== 1'b0 || step_cnt !== c0) begin
      n_err++; $display("FAIL glitch got pos=%0d err=%b steps=%0d want 65535/0/%0d", pos, err, step_cnt, c0);
    end
  endtask

  task automatic test_illegal;
    int c0;
    c0 = step_cnt;
    @(negedge clk); ab = ~ab; {qa, qb} = ab;
    repeat (10) @(negedge clk);
    n_cmp++; if (err !== 1'b1 || pos !== 16'hFFFF || step_cnt !== c0) begin
      n_err++; $display("FAIL illegal got err=%b pos=%0d steps=%0d want 1/65535/%0d", err, pos, step_cnt, c0);
    end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clr got %b want 0", err); end
    @(negedge clk); ab = ~ab; {qa, qb} = ab;
    repeat (5) @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_pre got %b want 0", err); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_set_wins got %b want 1", err); end
    repeat (4) @(negedge clk);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
  endtask

  task automatic test_index_clr;
    @(negedge clk); clr = 1'b1; @(negedge clk); clr = 1'b0;
    for (int i = 0; i < 21; i++) mv(1'b1, 10);
    mv(1'b0, 10);
    n_cmp++; if (pos !== 16'd20 || dir !== 1'b0) begin n_err++; $display("FAIL pre_index got pos=%0d dir=%b want 20/0", pos, dir); end
    @(negedge clk); qz = 1'b1; ab = nxt(ab, 1'b1); {qa, qb} = ab;
    repeat (6) @(negedge clk);
    n_cmp++; if (pos !== 16'd0 || step !== 1'b1 || dir !== 1'b1) begin
      n_err++; $display("FAIL index got pos=%0d step=%b dir=%b want 0/1/1", pos, step, dir);
    end
    repeat (4) @(negedge clk); qz = 1'b0;
    repeat (10) @(negedge clk);
    mv(1'b1, 10);
    n_cmp++; if (pos !== 16'd1) begin n_err++; $display("FAIL index_fall got %0d want 1", pos); end
    mv(1'b1, 10); mv(1'b1, 10); mv(1'b0, 10);
    n_cmp++; if (pos !== 16'd2 || dir !== 1'b0) begin n_err++; $display("FAIL pre_clr got pos=%0d dir=%b want 2/0", pos, dir); end
    @(negedge clk); ab = nxt(ab, 1'b1); {qa, qb} = ab;
    repeat (5) @(negedge clk);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    n_cmp++; if (pos !== 16'd0 || step !== 1'b1 || dir !== 1'b1) begin
      n_err++; $display("FAIL clr_step got pos=%0d step=%b dir=%b want 0/1/1", pos, step, dir);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_enable;
    int c0;
    mv(1'b0, 10);
    c0 = step_cnt;
    en = 1'b0;
    for (int i = 0; i < 4; i++) mv(1'b1, 10);
    n_cmp++; if (pos !== 16'hFFFF || dir !== 1'b0 || step_cnt !== c0) begin
      n_err++; $display("FAIL en0 got pos=%0d dir=%b steps=%0d want 65535/0/%0d", pos, dir, step_cnt, c0);
    end
    en = 1'b1;
    mv(1'b1, 10);
    n_cmp++; if (pos !== 16'd0 || dir !== 1'b1) begin n_err++; $display("FAIL en1 got pos=%0d dir=%b want 0/1", pos, dir); end
  endtask

  task automatic test_reset_11;
    mv(1'b1, 10); mv(1'b1, 10);
    n_cmp++; if (pos !== 16'd2) begin n_err++; $display("FAIL pre_rst got %0d want 2", pos); end
    @(negedge clk); rst = 1'b0; ab = 2'b11; {qa, qb} = ab;
    #1;
    n_cmp++; if (pos !== 16'd0 || dir !== 1'b0) begin n_err++; $display("FAIL async_rst got pos=%0d dir=%b want 0/0", pos, dir); end
    repeat (3) @(negedge clk); rst = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (err !== 1'b0 || pos !== 16'd0) begin n_err++; $display("FAIL prime_11 got err=%b pos=%0d want 0/0", err, pos); end
    mv(1'b1, 10);
    n_cmp++; if (pos !== 16'd1 || dir !== 1'b1 || err !== 1'b0) begin
      n_err++; $display("FAIL after_prime got pos=%0d dir=%b err=%b want 1/1/0", pos, dir, err);
    end
  endtask

  initial begin
    test_reset;
    test_up_count;
    test_wrap;
    test_glitch;
    test_illegal;
    test_index_clr;
    test_enable;
    test_reset_11;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
